// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: decode constants, states, instruction classes and select encodings
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_LH = 6'h21,
                         OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_LUI = 6'h0F, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_JR = 6'h08;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_SW, C_BEQ, C_JR, C_JAL, C_ILL} iclass_t;
  localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BEQ = 3'd1, NPC_JAL = 3'd2, NPC_RS = 3'd3;
  localparam logic [1:0] RA_RD = 2'd0, RA_RT = 2'd1, RA_31 = 2'd2;
  localparam logic [2:0] RD_ALU = 3'd0, RD_DM = 3'd1, RD_LUI = 3'd2, RD_PC4 = 3'd3,
                         RD_LH = 3'd4, RD_SLT = 3'd5;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLL = 3'd3;
  localparam logic [2:0] B_READ2 = 3'd0, B_SIMM = 3'd1, B_ZIMM = 3'd2, B_SHAMT = 3'd3;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: maps an instruction word to its class and static datapath selects
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic        a1_op,
  output logic [1:0]  reg_addr_op,
  output logic [2:0]  reg_data_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_b_op,
  output logic [2:0]  next_pc_op
);
  logic [5:0] op, fn;
  logic unused_fields;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];
  always_comb begin
    cls = C_ILL;
    a1_op = 1'b0;
    reg_addr_op = RA_RD;
    reg_data_op = RD_ALU;
    alu_op = ALU_ADD;
    alu_b_op = B_READ2;
    next_pc_op = NPC_PC4;
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADD, FN_ADDU: cls = C_ALU;
          FN_SUB, FN_SUBU: begin cls = C_ALU; alu_op = ALU_SUB; end
          FN_SLT: begin cls = C_ALU; reg_data_op = RD_SLT; end
          FN_SLL: begin cls = C_ALU; a1_op = 1'b1; alu_b_op = B_SHAMT; alu_op = ALU_SLL; end
          FN_JR: begin cls = C_JR; next_pc_op = NPC_RS; end
          default: cls = C_ILL;
        endcase
      OP_ORI: begin cls = C_ALU; reg_addr_op = RA_RT; alu_b_op = B_ZIMM; alu_op = ALU_OR; end
      OP_LUI: begin cls = C_ALU; reg_addr_op = RA_RT; reg_data_op = RD_LUI; end
      OP_LW, OP_LH: begin
        cls = C_LOAD;
        reg_addr_op = RA_RT;
        reg_data_op = op == OP_LW ? RD_DM : RD_LH;
        alu_b_op = B_SIMM;
      end
      OP_SW: begin cls = C_SW; alu_b_op = B_SIMM; end
      OP_BEQ: begin cls = C_BEQ; alu_op = ALU_SUB; next_pc_op = NPC_BEQ; end
      OP_JAL: begin cls = C_JAL; reg_addr_op = RA_31; reg_data_op = RD_PC4; next_pc_op = NPC_JAL; end
      default: cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        ir_en,
  output logic        pc_en,
  output logic [2:0]  next_pc_op,
  output logic        reg_write,
  output logic        a1_op,
  output logic [1:0]  reg_addr_op,
  output logic [2:0]  reg_data_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_b_op,
  output logic        mem_write,
  output logic        instr_done,
  output logic        illegal,
  output logic [2:0]  state
);
  state_t state_q, state_n;
  iclass_t cls;
  logic d_a1;
  logic [1:0] d_ra;
  logic [2:0] d_rd, d_alu, d_b, d_npc;
  logic fin, act;
  mips_ctrl_decode u_dec (
    .instr(instr), .cls(cls), .a1_op(d_a1), .reg_addr_op(d_ra), .reg_data_op(d_rd),
    .alu_op(d_alu), .alu_b_op(d_b), .next_pc_op(d_npc)
  );
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_n;
  always_comb begin
    state_n = S_FETCH;
    case (state_q)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: state_n = cls == C_ILL ? S_FETCH : cls == C_JAL ? S_WB : S_EXEC;
      S_EXEC: state_n = (cls == C_BEQ || cls == C_JR) ? S_FETCH :
                        (cls == C_LOAD || cls == C_SW) ? S_MEM : S_WB;
      S_MEM: state_n = cls == C_SW ? S_FETCH : S_WB;
      default: state_n = S_FETCH;
    endcase
  end
  // An instruction ends exactly when the sequencer is about to return to FETCH.
  assign fin = state_q != S_FETCH && state_n == S_FETCH;
  assign act = state_q == S_EXEC || state_q == S_MEM || state_q == S_WB;
  assign state = state_q;
  assign ir_en = !reset && state_q == S_FETCH;
  assign pc_en = !reset && fin;
  assign instr_done = !reset && fin;
  assign reg_write = !reset && state_q == S_WB;
  assign mem_write = !reset && state_q == S_MEM && cls == C_SW;
  assign illegal = !reset && state_q == S_DECODE && cls == C_ILL;
  assign next_pc_op = fin ? d_npc : NPC_PC4;
  assign a1_op = act && d_a1;
  assign reg_addr_op = act ? d_ra : RA_RD;
  assign reg_data_op = act ? d_rd : RD_ALU;
  assign alu_op = act ? d_alu : ALU_ADD;
  assign alu_b_op = act ? d_b : B_READ2;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized check of the multi-cycle controller against a latency-table model
module tb_mips_mc_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = '0;
  logic ir_en, pc_en, reg_write, a1_op, mem_write, instr_done, illegal;
  logic [2:0] next_pc_op, reg_data_op, alu_op, alu_b_op, state;
  logic [1:0] reg_addr_op;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .ir_en(ir_en), .pc_en(pc_en),
    .next_pc_op(next_pc_op), .reg_write(reg_write), .a1_op(a1_op), .reg_addr_op(reg_addr_op),
    .reg_data_op(reg_data_op), .alu_op(alu_op), .alu_b_op(alu_b_op), .mem_write(mem_write),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; bit wr; bit sw; bit ill; int dst; int dat; int alu; int b; int a1; int npc;
  } info_t;

  int nerr = 0, ncheck = 0;
  bit chk_on = 0;
  int e_state = 0;
  bit e_last = 0;
  info_t e_i;
  int rec_st[8], rec_rw[8], rec_mw[8], rec_pe[8], rec_npc[8], rec_ra[8], rec_rd[8], rec_ill[8];
  int ndone;

  task automatic chk(input string nm, input int got, input int exp);
    ncheck++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t (instr=%h)", nm, got, exp, $time, instr);
    end
  endtask

  // Expected behaviour per instruction: latency, what it writes, and its select values.
  function automatic info_t model(input logic [31:0] w);
    info_t r;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    r = '{default: 0};
    r.ill = 1;
    r.lat = 2;
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h00}) begin
        r = '{default: 0};
        r.lat = 4; r.wr = 1;
        if (fn == 6'h22 || fn == 6'h23) r.alu = 1;
        if (fn == 6'h2A) r.dat = 5;
        if (fn == 6'h00) begin r.a1 = 1; r.b = 3; r.alu = 3; end
      end else if (fn == 6'h08) begin
        r.ill = 0; r.lat = 3; r.npc = 3;
      end
    end else begin
      case (op)
        6'h0D: begin r.ill = 0; r.lat = 4; r.wr = 1; r.dst = 1; r.alu = 2; r.b = 2; end
        6'h0F: begin r.ill = 0; r.lat = 4; r.wr = 1; r.dst = 1; r.dat = 2; end
        6'h23, 6'h21: begin
          r.ill = 0; r.lat = 5; r.wr = 1; r.dst = 1; r.b = 1; r.dat = op == 6'h23 ? 1 : 4;
        end
        6'h2B: begin r.ill = 0; r.lat = 4; r.sw = 1; r.b = 1; end
        6'h04: begin r.ill = 0; r.lat = 3; r.alu = 1; r.npc = 1; end
        6'h03: begin r.ill = 0; r.lat = 3; r.wr = 1; r.dst = 2; r.dat = 3; r.npc = 2; end
        default: ;
      endcase
    end
    return r;
  endfunction

  // State visited at step i: steps count up through 0..4, skipping EXEC/MEM where the class has none.
  function automatic int path_state(input info_t r, input int i);
    if (r.lat == 3 && r.npc == 2) return i == 2 ? 4 : i;
    if (r.lat == 4 && !r.sw) return i == 3 ? 4 : i;
    return i;
  endfunction

  always @(negedge clk) if (chk_on) begin
    chk("state", state, e_state);
    chk("ir_en", ir_en, !reset && e_state == 0);
    chk("pc_en", pc_en, !reset && e_last);
    chk("instr_done", instr_done, !reset && e_last);
    chk("reg_write", reg_write, !reset && e_last && e_i.wr);
    chk("mem_write", mem_write, !reset && e_last && e_i.sw);
    chk("illegal", illegal, !reset && e_state == 1 && e_i.ill);
    chk("next_pc_op", next_pc_op, e_last ? e_i.npc : 0);
    chk("a1_op", a1_op, e_state >= 2 ? e_i.a1 : 0);
    chk("reg_addr_op", reg_addr_op, e_state >= 2 ? e_i.dst : 0);
    chk("reg_data_op", reg_data_op, e_state >= 2 ? e_i.dat : 0);
    chk("alu_op", alu_op, e_state >= 2 ? e_i.alu : 0);
    chk("alu_b_op", alu_b_op, e_state >= 2 ? e_i.b : 0);
  end

  // Runs up to n steps of one instruction, starting in a FETCH cycle just after a rising edge.
  task automatic run(input logic [31:0] w, input int n);
    info_t r;
    r = model(w);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      rec_st[i] = -1; rec_rw[i] = 0; rec_mw[i] = 0; rec_pe[i] = 0;
      rec_npc[i] = 0; rec_ra[i] = 0; rec_rd[i] = 0; rec_ill[i] = 0;
    end
    for (int i = 0; i < r.lat && i < n; i++) begin
      if (i == 0) instr = w;
      e_i = r;
      e_state = path_state(r, i);
      e_last = (i == r.lat - 1);
      chk_on = 1;
      #1;
      rec_st[i] = state; rec_rw[i] = reg_write; rec_mw[i] = mem_write; rec_pe[i] = pc_en;
      rec_npc[i] = next_pc_op; rec_ra[i] = reg_addr_op; rec_rd[i] = reg_data_op;
      rec_ill[i] = illegal;
      if (instr_done) ndone++;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0] op, fn;
    int k;
    w = $urandom();
    k = $urandom_range(0, 14);
    op = 6'h00;
    fn = 6'h20;
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h21;
      2: fn = 6'h22;
      3: fn = 6'h23;
      4: fn = 6'h2A;
      5: fn = 6'h00;
      6: fn = 6'h08;
      7: op = 6'h0D;
      8: op = 6'h0F;
      9: op = $urandom_range(0, 1) ? 6'h23 : 6'h21;
      10: op = 6'h2B;
      11: op = 6'h04;
      12: op = 6'h03;
      13: do op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h0D, 6'h23, 6'h21, 6'h2B, 6'h04, 6'h0F, 6'h03});
      default: do fn = 6'($urandom_range(0, 63));
               while (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h00, 6'h08});
    endcase
    w[31:26] = op;
    if (op == 6'h00) w[5:0] = fn;
    return w;
  endfunction

  initial begin
    e_i = model(32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    e_state = 0;
    e_last = 0;
    chk_on = 1;
    @(posedge clk);
    #1;
    reset = 0;

    run(32'h8C080004, 8);
    for (int i = 0; i < 5; i++) chk("lw_path", rec_st[i], i);
    chk("lw_wb_reg_write", rec_rw[4], 1);
    chk("lw_wb_reg_addr_op", rec_ra[4], 1);
    chk("lw_wb_reg_data_op", rec_rd[4], 1);
    chk("lw_wb_pc_en", rec_pe[4], 1);
    chk("lw_done_pulses", ndone, 1);

    run(32'hAC080004, 8);
    chk("sw_mem_write", rec_mw[3], 1);
    chk("sw_early_mem_write", rec_mw[0] + rec_mw[1] + rec_mw[2], 0);
    chk("sw_reg_write", rec_rw[0] + rec_rw[1] + rec_rw[2] + rec_rw[3], 0);

    run(32'h10000003, 8);
    chk("beq_exec_pc_en", rec_pe[2], 1);
    chk("beq_exec_next_pc_op", rec_npc[2], 1);
    chk("beq_then_fetch", state, 0);

    run(32'h0C000010, 8);
    chk("jal_wb_state", rec_st[2], 4);
    chk("jal_wb_reg_addr_op", rec_ra[2], 2);
    chk("jal_wb_reg_data_op", rec_rd[2], 3);
    chk("jal_wb_next_pc_op", rec_npc[2], 2);
    chk("jal_wb_reg_write", rec_rw[2], 1);

    run(32'hFC000000, 8);
    chk("ill_illegal", rec_ill[1], 1);
    chk("ill_pc_en", rec_pe[1], 1);
    chk("ill_next_pc_op", rec_npc[1], 0);
    chk("ill_then_fetch", state, 0);

    run(32'h0, 8);
    chk("nop_wb_state", rec_st[3], 4);
    chk("nop_done_pulses", ndone, 1);

    run(32'h8C080004, 3);
    reset = 1;
    e_state = 3;
    e_last = 0;
    #1;
    chk("rst_mem_reg_write", reg_write, 0);
    @(posedge clk);
    #1;
    e_state = 0;
    chk("rst_state", state, 0);
    chk("rst_fetch_reg_write", reg_write, 0);
    chk("rst_fetch_ir_en", ir_en, 0);
    @(posedge clk);
    #1;
    reset = 0;

    for (int n = 0; n < 300; n++) run(rand_instr(), 8);
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit that decodes the current instruction and sequences the control signals consumed by the MIPS datapath (PC select, GRF address/data select, ALU operand/op select, DM write). It is the control-side counterpart of the datapath's control interface and replaces a single-cycle combinational controller. It runs each instruction through FETCH/DECODE/EXEC/MEM/WB states, so the datapath can register IR, PC and memory data between phases.

## Interface

Parameters
- none. All encodings are fixed in `mips_ctrl_pkg`.

Ports
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction from the datapath IR; must be stable from DECODE to the end of the instruction.
- `ir_en`  out  1  IR load enable.
- `pc_en`  out  1  PC update enable.
- `next_pc_op`  out  3  PC source: 0 = PC+4, 1 = beq target (the datapath applies the zero test), 2 = jal target, 3 = GPR[rs].
- `reg_write`  out  1  GRF write enable.
- `a1_op`  out  1  GRF read port 1 address: 0 = rs, 1 = rt.
- `reg_addr_op`  out  2  GRF write address: 0 = rd, 1 = rt, 2 = 31.
- `reg_data_op`  out  3  GRF write data: 0 = ALU, 1 = DM word, 2 = lui, 3 = PC+4, 4 = lh, 5 = slt.
- `alu_op`  out  3  ALU operation: 0 = ADD, 1 = SUB, 2 = OR, 3 = SLL.
- `alu_b_op`  out  3  ALU B operand: 0 = read2, 1 = sign-extended imm, 2 = zero-extended imm, 3 = shamt.
- `mem_write`  out  1  DM write enable.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in DECODE when the instruction is unrecognised.
- `state`  out  3  current state, for debug.

## Operation

- State register encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- Outputs are combinational from `state` and `instr`. Every select output is 0 unless listed below.
- FETCH: `ir_en` = 1. Next state is always DECODE.

Instruction classes and paths:
- R-ALU (add/addu = ADD, sub/subu = SUB): EXEC, then WB with `reg_write` = 1 and `reg_addr_op` = 0.
- sll: `a1_op` = 1, `alu_b_op` = 3, `alu_op` = SLL. Path is EXEC, then WB writing rd.
- slt: EXEC, then WB with `reg_data_op` = 5, writing rd.
- ori: `alu_b_op` = 2, `alu_op` = OR. Path is EXEC, then WB writing rt.
- lui: EXEC, then WB with `reg_data_op` = 2, writing rt.
- lw / lh: `alu_b_op` = 1, `alu_op` = ADD. Path is EXEC, MEM, then WB with `reg_data_op` = 1 (lw) or 4 (lh), writing rt.
- sw: `alu_b_op` = 1, `alu_op` = ADD. Path is EXEC, then MEM with `mem_write` = 1; MEM is the final state.
- beq: `alu_op` = SUB. EXEC is the final state, with `next_pc_op` = 1.
- jr: EXEC is the final state, with `next_pc_op` = 3.
- jal: WB directly from DECODE, with `reg_addr_op` = 2, `reg_data_op` = 3, `next_pc_op` = 2.
- Unknown opcode/funct: DECODE is the final state with `next_pc_op` = 0, and `illegal` = 1.

Final-state rules:
- In every final state, `pc_en` = 1 and `instr_done` = 1, and the next state is FETCH.
- `next_pc_op` = 0 in final states unless set otherwise above.
- ALU and operand selects are held constant from EXEC through WB of the same instruction.
- `reg_write` and `mem_write` are asserted only in the final state, for exactly one cycle.

Decode constants (opcode/funct in hex):
- R-type: opcode 00, with funct add 20, addu 21, sub 22, subu 23, slt 2A, sll 00, jr 08.
- Other opcodes: ori 0D, lw 23, lh 21, sw 2B, beq 04, lui 0F, jal 03.
- The all-zero word decodes as sll $0 and runs as a normal 4-cycle R-ALU instruction.

## Timing

- Reset: when `reset` = 1 at an edge, the state becomes FETCH.
- While `reset` is high, `reg_write`, `mem_write`, `pc_en`, `ir_en`, `instr_done` and `illegal` are forced to 0, including when reset arrives mid-instruction.
- After reset, all outputs are 0 except `ir_en` = 1 in FETCH.
- Latency in cycles: R-ALU/sll/slt/ori/lui 4, lw/lh 5, sw 4, beq 3, jr 3, jal 3, illegal 2.
- No stalls or back-pressure. Instructions issue back-to-back: FETCH follows the final state with no gap.

## Structure

- Package `mips_ctrl_pkg` holds:
  - opcode/funct constants;
  - the state enum;
  - select encodings for `next_pc_op`, `reg_addr_op`, `reg_data_op`, `alu_op`, `alu_b_op`;
  - the instruction-class enum.
- Sub-module `mips_ctrl_decode` is a combinational mapping from `instr` to instruction class plus static selects. The top level holds the state register, next-state logic and phase gating of the write enables.

## Test plan

- Reset asserted during the MEM state of lw: next cycle `state` = 0, and `reg_write` = 0 throughout.
- `instr` = 0x8C080004 (lw $t0, 4($0)): states 0,1,2,3,4. In WB, `reg_write` = 1, `reg_addr_op` = 1, `reg_data_op` = 1, `pc_en` = 1. `instr_done` pulses once.
- `instr` = 0xAC080004 (sw): `mem_write` = 1 only in MEM (cycle 4). `reg_write` is never 1.
- `instr` = 0x10000003 (beq): `pc_en` = 1 and `next_pc_op` = 1 in EXEC (cycle 3). The following cycle is FETCH.
- `instr` = 0x0C000010 (jal): in cycle 3 (WB), `reg_addr_op` = 2, `reg_data_op` = 3, `next_pc_op` = 2, `reg_write` = 1.
- `instr` = 0xFC000000 (illegal): `illegal` = 1, `pc_en` = 1, `next_pc_op` = 0 in DECODE. The next state is FETCH.
